// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/call/return redirect and circular return-address stack
//
// Purpose: holds the fetch PC and selects the next one each cycle from exception vector,
// return-stack top, branch target or sequential step. Calls push the return address onto
// a small circular stack whose oldest entry is overwritten when it is full.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   start_i      run enable; low holds all state
//   stall_i      hazard stall; high holds all state (exceptions still accepted)
//   br_i         taken branch/jump to br_target_i
//   call_i       branch to br_target_i and push pc_o+STEP
//   ret_i        jump to popped address (br_target_i when the stack is empty)
//   br_target_i  redirect target
//   exc_i        exception/flush request
//   exc_vec_i    exception handler address
//   pc_o         current PC (registered)
//   valid_o      pc_o is a fetched address
//   ras_empty_o  stack count == 0
//   ras_full_o   stack count == RAS_DEPTH
//   ras_ovf_o    sticky: a push overwrote a live entry
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             br_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_vec_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_ovf_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [WIDTH-1:0] ras_wdata;

  logic             empty;
  logic             full;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] top_addr;
  logic [WIDTH-1:0] seq_pc;

  // ptr_q points at the next free slot; the top entry sits just below it.
  // Because the pointer wraps, a push while full lands on the oldest entry.
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign top_idx  = ptr_q - PTR_W'(1);
  assign top_addr = ras_q[top_idx];
  assign seq_pc   = pc_q + STEP_W;

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q | start_i;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ovf_d     = ovf_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_wdata = seq_pc;

    if (start_i && exc_i) begin
      // Flush wins over stall and every other request.
      pc_d  = exc_vec_i;
      cnt_d = '0;
    end else if (start_i && !stall_i) begin
      if (ret_i) begin
        pc_d = empty ? br_target_i : top_addr;
        if (call_i) begin
          // Call+return: the return address replaces the popped top in place.
          ras_we = 1'b1;
          if (empty) begin
            ras_waddr = ptr_q;
            ptr_d     = ptr_q + PTR_W'(1);
            cnt_d     = CNT_W'(1);
          end else begin
            ras_waddr = top_idx;
          end
        end else if (!empty) begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (call_i) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        pc_d   = br_target_i;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (br_i) begin
        pc_d = br_target_i;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stack storage is not reset; the count alone decides which entries are live.
  // A write in a reset cycle is suppressed so reset aborts the update.
  always_ff @(posedge clk_i) begin
    if (ras_we && !rst_i) begin
      ras_q[ras_waddr] <= ras_wdata;
    end
  end

  assign pc_o        = pc_q;
  assign valid_o     = valid_q;
  assign ras_empty_o = empty;
  assign ras_full_o  = full;
  assign ras_ovf_o   = ovf_q;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC bit width.
REQ-002 SHALL have parameter RESET_VEC, default 0, meaning WIDTH-bit PC value loaded at reset.
REQ-003 SHALL have parameter STEP, default 4, meaning sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have port clk_i, input, 1, system clock.
REQ-006 SHALL have port rst_i, input, 1; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port start_i, input, 1, run enable; low holds PC.
REQ-008 SHALL have port stall_i, input, 1, hazard stall; high holds PC.
REQ-009 SHALL have port br_i, input, 1, taken branch/jump redirect.
REQ-010 SHALL have port call_i, input, 1, call: redirect plus push return address.
REQ-011 SHALL have port ret_i, input, 1, return: redirect to popped address.
REQ-012 SHALL have port br_target_i, input, WIDTH, target for br_i/call_i; fallback target for ret_i on empty stack.
REQ-013 SHALL have port exc_i, input, 1, exception/flush request.
REQ-014 SHALL have port exc_vec_i, input, WIDTH, exception handler address.
REQ-015 SHALL have port pc_o, output, WIDTH, current PC.
REQ-016 SHALL have port valid_o, output, 1, pc_o is a fetched address.
REQ-017 SHALL have port ras_empty_o, output, 1, stack count == 0.
REQ-018 SHALL have port ras_full_o, output, 1, stack count == RAS_DEPTH.
REQ-019 SHALL have port ras_ovf_o, output, 1, sticky: a push overwrote a live entry.

Function
REQ-020 SHALL register pc_o; all updates on rising clk_i; next-PC selection combinational, one-cycle latency from any input to pc_o.
REQ-021 SHALL advance when adv = start_i & ~stall_i; otherwise pc_o, stack state and flags hold, except REQ-022.
REQ-022 SHALL treat exc_i (when start_i=1) as overriding stall_i: pc_o <= exc_vec_i, stack count <= 0, ras_ovf_o unchanged, all other requests ignored.
REQ-023 SHALL, when adv and no exc_i, apply priority ret_i > call_i > br_i > sequential.
REQ-024 SHALL on ret_i with count>0: pc_o <= top entry, count decrements; with count==0: pc_o <= br_target_i, count stays 0.
REQ-025 SHALL on call_i with ret_i also high: pc_o <= top entry (or br_target_i if empty), top entry replaced by pc_o+STEP, count unchanged (1 if was 0).
REQ-026 SHALL on call_i alone: push pc_o+STEP, pc_o <= br_target_i.
REQ-027 SHALL on push with count==RAS_DEPTH: overwrite oldest entry (circular pointer wrap), count stays RAS_DEPTH, set ras_ovf_o.
REQ-028 SHALL on br_i alone: pc_o <= br_target_i; stack untouched.
REQ-029 SHALL otherwise: pc_o <= pc_o + STEP, modulo 2^WIDTH (wrap, no flag).
REQ-030 SHALL keep stack pointer modulo RAS_DEPTH; count range 0..RAS_DEPTH.
REQ-031 SHALL drive valid_o registered: 1 in any cycle after a cycle with start_i=1 and no reset; 0 after reset until first such cycle; held during stall.
REQ-032 SHALL ignore call_i/ret_i/br_i while start_i=0 or stall_i=1 (no stack change).

Reset
REQ-033 SHALL on rst_i high, immediately and independent of clk_i: pc_o=RESET_VEC, valid_o=0, count=0, pointer=0, ras_ovf_o=0, ras_empty_o=1, ras_full_o=0.
REQ-034 SHALL abort any in-progress update on reset mid-operation; stack entry contents need not be cleared.
REQ-035 SHALL resume from RESET_VEC on the first clk_i edge with rst_i low and start_i high.

Verification
REQ-036 Reset then start_i=1 for 3 cycles, defaults -> pc_o 0x0,0x4,0x8,0xC; valid_o 0 then 1.
REQ-037 pc_o=0x100, stall_i=1 with br_i=1, br_target_i=0x200 -> pc_o stays 0x100; stall released, br_i=1 -> 0x200.
REQ-038 pc_o=0x10, call_i target 0x80; then ret_i -> pc_o 0x80 then 0x14; ras_empty_o 0,1.
REQ-039 RAS_DEPTH=4: 5 calls from 0x0,0x40,0x80,0xC0,0x100 -> ras_full_o=1, ras_ovf_o=1; 4 rets return 0x104,0xC4,0x84,0x44; 5th ret uses br_target_i.
REQ-040 stall_i=1, exc_i=1, exc_vec_i=0x800, ret_i=1, two live entries -> pc_o 0x800, ras_empty_o=1.
REQ-041 pc_o=0xFFFFFFFC, sequential step -> 0x00000000; assert rst_i asynchronously mid-cycle -> pc_o=0 before next edge.
